// File: rtl/dmem_responder_if.sv
// Pipeline-side and backing-memory-side signals of the MEM-stage data-memory responder.
// The slave modport is the responder's view; master is the pipeline/memory side.
interface dmem_responder_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] Addr_i;
    logic [31:0] WriteData_i;
    logic [31:0] ReadData_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    modport slave (
        input  MemRead_i, MemWrite_i, Addr_i, WriteData_i,
        output ReadData_o, stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i
    );

    modport master (
        output MemRead_i, MemWrite_i, Addr_i, WriteData_i,
        input  ReadData_o, stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i
    );
endinterface

// File: rtl/dmem_responder.sv
// Purpose: MEM-stage direct-mapped write-back data cache, one word per line.
// Latency: hits serve in the request cycle; misses add memory ack latencies + 1 cycle.
// Backpressure: stall_o holds the pipeline on a miss until the refilled line hits.
module dmem_responder #(
    parameter int INDEX_BITS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, WB, ALLOC} state_t;

    state_t                r_state;
    logic [LINES-1:0]      r_valid;
    logic [LINES-1:0]      r_dirty;
    logic [TAG_BITS-1:0]   r_tag  [LINES];
    logic [31:0]           r_data [LINES];
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [31:0]           r_mem_addr;
    logic [31:0]           r_mem_wdata;

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_req;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_hit;

    assign w_idx = bus.Addr_i[INDEX_BITS+1:2];
    assign w_tag = bus.Addr_i[31:INDEX_BITS+2];
    assign w_req = bus.MemRead_i | bus.MemWrite_i;
    // A simultaneous read+write is a store, so the read path only sees pure loads.
    assign w_wr  = bus.MemWrite_i;
    assign w_rd  = bus.MemRead_i & ~bus.MemWrite_i;
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign bus.stall_o     = (r_state != IDLE) || (w_req && !w_hit);
    assign bus.ReadData_o  = (r_state == IDLE && w_rd && w_hit) ? r_data[w_idx] : '0;
    assign bus.mem_req_o   = r_mem_req;
    assign bus.mem_we_o    = r_mem_we;
    assign bus.mem_addr_o  = r_mem_addr;
    assign bus.mem_wdata_o = r_mem_wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            if (w_wr) begin
                                r_data[w_idx]  <= bus.WriteData_i;
                                r_dirty[w_idx] <= 1'b1;
                            end
                        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state     <= WB;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= {r_tag[w_idx], w_idx, 2'b00};
                            r_mem_wdata <= r_data[w_idx];
                        end else begin
                            r_state     <= ALLOC;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= {w_tag, w_idx, 2'b00};
                            r_mem_wdata <= '0;
                        end
                    end
                end
                WB: begin
                    if (bus.mem_ack_i) begin
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= ALLOC;
                        r_mem_we       <= 1'b0;
                        r_mem_addr     <= {w_tag, w_idx, 2'b00};
                        r_mem_wdata    <= '0;
                    end
                end
                ALLOC: begin
                    if (bus.mem_ack_i) begin
                        r_data[w_idx]  <= bus.mem_rdata_i;
                        r_tag[w_idx]   <= w_tag;
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= IDLE;
                        r_mem_req      <= 1'b0;
                        r_mem_we       <= 1'b0;
                        r_mem_addr     <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
